// File: rtl/wfg_drive_spi_rx_if.sv
// wfg_drive_spi_rx_if: valid/ready stream carrying received SPI words.
interface wfg_drive_spi_rx_if;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    modport master (output rx_data, rx_valid, input rx_ready);
    modport slave  (input rx_data, rx_valid, output rx_ready);
endinterface

// File: rtl/wfg_drive_spi_rx.sv
// wfg_drive_spi_rx: oversampled SPI peripheral receiver (CPHA=0) deserializing
// 8/16/24/32-bit words into a first-word fall-through FIFO on a valid/ready stream.
module wfg_drive_spi_rx #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en_i,
    input  logic                        cpol_i,
    input  logic                        lsb_first_i,
    input  logic [1:0]                  dlen_i,
    input  logic                        clear_i,
    input  logic                        spi_sclk_i,
    input  logic                        spi_cs_ni,
    input  logic                        spi_sdi_i,
    wfg_drive_spi_rx_if.master          rx,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
    output logic                        overflow_o,
    output logic                        frame_err_o,
    output logic                        busy_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t                        state_q, state_d;
    logic [SYNC_STAGES-1:0][2:0]   sync_q, sync_d;
    logic [1:0]                    edge_q, edge_d;
    logic                          cpol_q, cpol_d, lsb_q, lsb_d;
    logic [1:0]                    dlen_q, dlen_d;
    logic [5:0]                    cnt_q, cnt_d, cnt_b, len;
    logic [31:0]                   sr_q, sr_d, sr_b;
    logic [31:0]                   mem_q [FIFO_DEPTH];
    logic [31:0]                   mem_d [FIFO_DEPTH];
    logic [AW-1:0]                 wp_q, wp_d, rp_q, rp_d;
    logic [LW-1:0]                 lvl_q, lvl_d;
    logic                          ovf_q, ovf_d, ferr_q, ferr_d;
    logic                          sclk_s, cs_s, sdi_s, sample, cs_fall, cs_rise;
    logic                          wrap, ferr_set, valid, full, pop, push_ok;
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], {spi_sclk_i, spi_cs_ni, spi_sdi_i}};
        sclk_s  = sync_q[SYNC_STAGES-1][2];
        cs_s    = sync_q[SYNC_STAGES-1][1];
        sdi_s   = sync_q[SYNC_STAGES-1][0];
        edge_d  = {sclk_s, cs_s};
        sample  = cpol_q ? (~sclk_s & edge_q[1]) : (sclk_s & ~edge_q[1]);
        cs_fall = ~cs_s & edge_q[0];
        cs_rise = cs_s & ~edge_q[0];
        len     = {1'b0, dlen_q, 3'b000} + 6'd8;
        // a completed word is pushed the cycle after its last bit; a new bit may start in that same cycle
        wrap    = (state_q == SHIFT) && (cnt_q == len);
        cnt_b   = wrap ? 6'd0 : cnt_q;
        sr_b    = wrap ? 32'd0 : sr_q;
    end
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        cpol_d   = cpol_q;
        lsb_d    = lsb_q;
        dlen_d   = dlen_q;
        ferr_set = 1'b0;
        if (state_q == IDLE) begin
            if (en_i && cs_fall) begin
                state_d = SHIFT;
                cnt_d   = '0;
                sr_d    = '0;
                cpol_d  = cpol_i;
                lsb_d   = lsb_first_i;
                dlen_d  = dlen_i;
            end
        end else begin
            cnt_d = cnt_b;
            sr_d  = sr_b;
            if (!en_i || cs_rise) begin
                state_d  = IDLE;
                cnt_d    = '0;
                sr_d     = '0;
                ferr_set = en_i && (cnt_q != 6'd0) && !wrap;
            end else if (sample) begin
                sr_d  = lsb_q ? (sr_b | (32'(sdi_s) << cnt_b[4:0])) : {sr_b[30:0], sdi_s};
                cnt_d = cnt_b + 6'd1;
            end
        end
    end
    always_comb begin
        valid   = lvl_q != '0;
        full    = lvl_q == LW'(FIFO_DEPTH);
        pop     = valid && rx.rx_ready;
        push_ok = wrap && (!full || pop);
        mem_d   = mem_q;
        if (push_ok) mem_d[wp_q] = sr_q;
        wp_d    = clear_i ? '0 : wp_q + AW'(push_ok);
        rp_d    = clear_i ? '0 : rp_q + AW'(pop);
        lvl_d   = clear_i ? '0 : lvl_q + LW'(push_ok) - LW'(pop);
        ovf_d   = !clear_i && (ovf_q || (wrap && full && !pop));
        ferr_d  = !clear_i && (ferr_q || ferr_set);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sync_q  <= {SYNC_STAGES{3'b010}};
            edge_q  <= 2'b01;
            cpol_q  <= 1'b0;
            lsb_q   <= 1'b0;
            dlen_q  <= '0;
            cnt_q   <= '0;
            sr_q    <= '0;
            mem_q   <= '{default: '0};
            wp_q    <= '0;
            rp_q    <= '0;
            lvl_q   <= '0;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            edge_q  <= edge_d;
            cpol_q  <= cpol_d;
            lsb_q   <= lsb_d;
            dlen_q  <= dlen_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            mem_q   <= mem_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            lvl_q   <= lvl_d;
            ovf_q   <= ovf_d;
            ferr_q  <= ferr_d;
        end
    end
    assign rx.rx_data   = valid ? mem_q[rp_q] : '0;
    assign rx.rx_valid  = valid;
    assign fifo_level_o = lvl_q;
    assign overflow_o   = ovf_q;
    assign frame_err_o  = ferr_q;
    assign busy_o       = state_q == SHIFT;
endmodule
